// File: rtl/serial_tx_buffered.sv
// serial_tx_buffered: double-buffered serial transmitter.
// A holding register queues the next word while the current frame shifts out,
// so consecutive frames run back-to-back. Bit order, frame length and bit
// period are latched per frame; Abort drops both the active and queued word.
module serial_tx_buffered #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 16,
    localparam int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             Load,
    input  logic [LEN_W-1:0] Len,
    input  logic             LsbFirst,
    input  logic [DIV_W-1:0] BitDiv,
    input  logic             Abort,
    output logic             Ready,
    output logic             TxBusy,
    output logic             TxDone,
    output logic             BitStrobe,
    output logic             Dout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [LEN_W-1:0] LEN_ZERO  = LEN_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_WIDTH = LEN_W'(WIDTH);
    localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

    // holding register (next frame)
    logic [WIDTH-1:0] hold_data_r;
    logic [LEN_W-1:0] hold_len_r;     // already the effective length, 1..WIDTH
    logic             hold_lsb_r;
    logic [DIV_W-1:0] hold_div_r;
    logic             hold_valid_r;
    logic             ready_r;

    // active frame
    logic [0:0]       state_r;
    logic [WIDTH-1:0] shift_r;        // current bit sits at [0] (LSB-first) or [WIDTH-1] (MSB-first)
    logic             cur_lsb_r;
    logic [DIV_W-1:0] cur_div_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [LEN_W-1:0] bit_cnt_r;      // bits still to come after the current one
    logic             dout_r;
    logic             strobe_r;
    logic             done_r;

    logic [LEN_W-1:0] len_eff_s;
    logic             frame_end_s;
    logic             xfer_s;
    logic [WIDTH-1:0] xfer_word_s;
    logic             xfer_bit_s;
    logic [WIDTH-1:0] next_word_s;
    logic             next_bit_s;

    // Effective length, frame-end/transfer decode and the shifter's next values
    always_comb begin
        len_eff_s   = Len;
        if ((Len == LEN_ZERO) || (Len > LEN_WIDTH)) begin
            len_eff_s = LEN_WIDTH;
        end else begin
            len_eff_s = Len;
        end
        frame_end_s = (state_r == ST_SHIFT) && (div_cnt_r == DIV_ZERO) && (bit_cnt_r == LEN_ZERO);
        xfer_s      = hold_valid_r && ((state_r == ST_IDLE) || frame_end_s);
        // MSB-first frames are left-aligned so the first bit is always at [WIDTH-1]
        if (hold_lsb_r) begin
            xfer_word_s = hold_data_r;
            xfer_bit_s  = hold_data_r[0];
        end else begin
            xfer_word_s = hold_data_r << (LEN_WIDTH - hold_len_r);
            xfer_bit_s  = xfer_word_s[WIDTH-1];
        end
        if (cur_lsb_r) begin
            next_word_s = shift_r >> 1'b1;
            next_bit_s  = next_word_s[0];
        end else begin
            next_word_s = shift_r << 1'b1;
            next_bit_s  = next_word_s[WIDTH-1];
        end
    end

    // Holding register: accept a word when empty, release it on transfer
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold_data_r  <= {WIDTH{1'b0}};
            hold_len_r   <= LEN_ZERO;
            hold_lsb_r   <= 1'b0;
            hold_div_r   <= DIV_ZERO;
            hold_valid_r <= 1'b0;
            ready_r      <= 1'b1;
        end else if (Abort) begin
            hold_valid_r <= 1'b0;
            ready_r      <= 1'b1;
        end else if (xfer_s) begin
            hold_valid_r <= 1'b0;
            ready_r      <= 1'b1;
        end else if (Load && ready_r) begin
            hold_data_r  <= DataIn;
            hold_len_r   <= len_eff_s;
            hold_lsb_r   <= LsbFirst;
            hold_div_r   <= BitDiv;
            hold_valid_r <= 1'b1;
            ready_r      <= 1'b0;
        end else begin
            hold_valid_r <= hold_valid_r;
            ready_r      <= ready_r;
        end
    end

    // Transmit engine: bit timing, shifting and status pulses
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= {WIDTH{1'b0}};
            cur_lsb_r <= 1'b0;
            cur_div_r <= DIV_ZERO;
            div_cnt_r <= DIV_ZERO;
            bit_cnt_r <= LEN_ZERO;
            dout_r    <= 1'b0;
            strobe_r  <= 1'b0;
            done_r    <= 1'b0;
        end else if (Abort) begin
            state_r   <= ST_IDLE;
            shift_r   <= {WIDTH{1'b0}};
            cur_lsb_r <= 1'b0;
            cur_div_r <= DIV_ZERO;
            div_cnt_r <= DIV_ZERO;
            bit_cnt_r <= LEN_ZERO;
            dout_r    <= 1'b0;
            strobe_r  <= 1'b0;
            done_r    <= 1'b0;
        end else if (xfer_s) begin
            // start of a frame, from idle or straight after the previous one
            state_r   <= ST_SHIFT;
            shift_r   <= xfer_word_s;
            cur_lsb_r <= hold_lsb_r;
            cur_div_r <= hold_div_r;
            div_cnt_r <= hold_div_r;
            bit_cnt_r <= hold_len_r - LEN_ONE;
            dout_r    <= xfer_bit_s;
            strobe_r  <= 1'b1;
            // TxDone marks the last cycle of the frame, so it is set on entry to that cycle
            done_r    <= (hold_len_r == LEN_ONE) && (hold_div_r == DIV_ZERO);
        end else begin
            strobe_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    dout_r <= 1'b0;
                end
                ST_SHIFT: begin
                    if (div_cnt_r != DIV_ZERO) begin
                        div_cnt_r <= div_cnt_r - DIV_ONE;
                        done_r    <= (div_cnt_r == DIV_ONE) && (bit_cnt_r == LEN_ZERO);
                    end else if (bit_cnt_r != LEN_ZERO) begin
                        shift_r   <= next_word_s;
                        dout_r    <= next_bit_s;
                        strobe_r  <= 1'b1;
                        bit_cnt_r <= bit_cnt_r - LEN_ONE;
                        div_cnt_r <= cur_div_r;
                        done_r    <= (bit_cnt_r == LEN_ONE) && (cur_div_r == DIV_ZERO);
                    end else begin
                        state_r <= ST_IDLE;
                        dout_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    dout_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Ready     = ready_r;
    assign TxBusy    = (state_r == ST_SHIFT);
    assign TxDone    = done_r;
    assign BitStrobe = strobe_r;
    assign Dout      = dout_r;

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Testbench for serial_tx_buffered: directed cases plus random traffic,
// checked every cycle against a frame-level reference model.
module tb_serial_tx_buffered;

    logic        Clk;
    logic        Reset;
    logic [31:0] DataIn;
    logic        Load;
    logic [5:0]  Len;
    logic        LsbFirst;
    logic [15:0] BitDiv;
    logic        Abort;
    logic        Ready;
    logic        TxBusy;
    logic        TxDone;
    logic        BitStrobe;
    logic        Dout;

    serial_tx_buffered dut (
        .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .Load(Load), .Len(Len),
        .LsbFirst(LsbFirst), .BitDiv(BitDiv), .Abort(Abort), .Ready(Ready),
        .TxBusy(TxBusy), .TxDone(TxDone), .BitStrobe(BitStrobe), .Dout(Dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // one sample = what the outputs should show for one clock cycle
    typedef struct {
        bit dout;
        bit strobe;
        bit done;
    } samp_t;

    samp_t       exp_q[$];
    samp_t       cur_e;
    bit          cur_busy;
    bit          pend_v;
    bit [31:0]   pend_data;
    int          pend_len;
    bit          pend_lsb;
    int          pend_div;

    // observation statistics for directed cases
    logic [63:0] rec;
    int          n_busy;
    int          n_strobe;
    int          n_done;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_v     = 1'b0;
        cur_e      = '{1'b0, 1'b0, 1'b0};
        cur_busy   = 1'b0;
    endtask

    // turn a queued word into its cycle-by-cycle waveform
    task automatic expand_pending();
        for (int i = 0; i < pend_len; i++) begin
            int idx;
            idx = pend_lsb ? i : (pend_len - 1 - i);
            for (int j = 0; j <= pend_div; j++) begin
                samp_t s;
                s.dout   = pend_data[idx];
                s.strobe = (j == 0);
                s.done   = (i == pend_len - 1) && (j == pend_div);
                exp_q.push_back(s);
            end
        end
    endtask

    // advance the model by one rising edge using the inputs present at that edge
    task automatic model_step();
        bit was_pend;
        if (Reset) begin
            model_reset();
            return;
        end
        was_pend = pend_v;
        if (Abort) begin
            model_reset();
        end else begin
            if ((exp_q.size() == 0) && pend_v) begin
                expand_pending();
                pend_v = 1'b0;
            end
            if (exp_q.size() != 0) begin
                cur_e    = exp_q.pop_front();
                cur_busy = 1'b1;
            end else begin
                cur_e    = '{1'b0, 1'b0, 1'b0};
                cur_busy = 1'b0;
            end
            if (Load && !was_pend) begin
                pend_v    = 1'b1;
                pend_data = DataIn;
                pend_len  = ((Len == 6'd0) || (Len > 6'd32)) ? 32 : int'(Len);
                pend_lsb  = LsbFirst;
                pend_div  = int'(BitDiv);
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("dout",   {63'd0, Dout},      {63'd0, cur_e.dout});
        check_eq("strobe", {63'd0, BitStrobe}, {63'd0, cur_e.strobe});
        check_eq("done",   {63'd0, TxDone},    {63'd0, cur_e.done});
        check_eq("busy",   {63'd0, TxBusy},    {63'd0, cur_busy});
        check_eq("ready",  {63'd0, Ready},     {63'd0, !pend_v});
    endtask

    task automatic clear_stats();
        rec      = 64'd0;
        n_busy   = 0;
        n_strobe = 0;
        n_done   = 0;
    endtask

    // one clock: check previous edge's result, drive new inputs, step the model
    task automatic cycle(input bit ld, input logic [31:0] d, input logic [5:0] l,
                         input bit lsb, input logic [15:0] dv, input bit ab);
        @(negedge Clk);
        check_outputs();
        if (TxBusy) n_busy++;
        if (BitStrobe) begin
            rec = {rec[62:0], Dout};
            n_strobe++;
        end
        if (TxDone) n_done++;
        Load     = ld;
        DataIn   = d;
        Len      = l;
        LsbFirst = lsb;
        BitDiv   = dv;
        Abort    = ab;
        @(posedge Clk);
        model_step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 6'd0, 1'b0, 16'd0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; DataIn = 32'd0; Len = 6'd0;
        LsbFirst = 1'b0; BitDiv = 16'd0; Abort = 1'b0;
        model_reset();
        clear_stats();
        idle_cycles(3);
        @(negedge Clk);
        Reset = 1'b0;

        // MSB-first, BitDiv=0: low byte of A5000000 is all zeros
        clear_stats();
        cycle(1'b1, 32'hA500_0000, 6'd8, 1'b0, 16'd0, 1'b0);
        idle_cycles(12);
        check_eq("msb0_bits", rec[7:0], 64'h00);
        check_eq("msb0_busy", n_busy, 8);

        clear_stats();
        cycle(1'b1, 32'h0000_00A5, 6'd8, 1'b0, 16'd0, 1'b0);
        idle_cycles(12);
        check_eq("msbA5_bits", rec[7:0], 64'hA5);
        check_eq("msbA5_strobes", n_strobe, 8);
        check_eq("msbA5_busy", n_busy, 8);
        check_eq("msbA5_done", n_done, 1);

        // LSB-first, 4 cycles per bit: bit sequence 1,0,1,0,0,1,0,1
        clear_stats();
        cycle(1'b1, 32'h0000_00A5, 6'd8, 1'b1, 16'd3, 1'b0);
        idle_cycles(40);
        check_eq("lsb_bits", rec[7:0], 64'hA5);
        check_eq("lsb_strobes", n_strobe, 8);
        check_eq("lsb_busy", n_busy, 32);

        // back-to-back: A=C, second load attempt while full is ignored, then B=3
        clear_stats();
        cycle(1'b1, 32'h0000_000C, 6'd4, 1'b0, 16'd1, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 6'd4, 1'b0, 16'd1, 1'b0);
        cycle(1'b1, 32'h0000_0003, 6'd4, 1'b0, 16'd1, 1'b0);
        idle_cycles(24);
        check_eq("b2b_bits", rec[7:0], 64'hC3);
        check_eq("b2b_busy", n_busy, 16);
        check_eq("b2b_done", n_done, 2);

        // Len=0 and Len=40 both mean a full 32-bit frame
        for (int k = 0; k < 2; k++) begin
            clear_stats();
            cycle(1'b1, 32'h8000_0001, (k == 0) ? 6'd0 : 6'd40, 1'b0, 16'd0, 1'b0);
            idle_cycles(36);
            check_eq("full_bits", rec[31:0], 64'h8000_0001);
            check_eq("full_busy", n_busy, 32);
            check_eq("full_done", n_done, 1);
        end

        // Abort at bit 3 with a second word pending
        clear_stats();
        cycle(1'b1, 32'h0000_00FF, 6'd8, 1'b0, 16'd0, 1'b0);
        cycle(1'b0, 32'd0, 6'd0, 1'b0, 16'd0, 1'b0);
        cycle(1'b1, 32'h0000_00FF, 6'd8, 1'b0, 16'd0, 1'b0);
        cycle(1'b0, 32'd0, 6'd0, 1'b0, 16'd0, 1'b0);
        cycle(1'b0, 32'd0, 6'd0, 1'b0, 16'd0, 1'b1);
        idle_cycles(20);
        check_eq("abort_busy", n_busy, 3);
        check_eq("abort_done", n_done, 0);
        check_eq("abort_strobes", n_strobe, 3);

        // async reset between edges in the middle of a frame
        cycle(1'b1, 32'hFFFF_FFFF, 6'd16, 1'b0, 16'd1, 1'b0);
        idle_cycles(5);
        #3 Reset = 1'b1;
        #1;
        check_eq("arst_dout", {63'd0, Dout}, 64'd0);
        check_eq("arst_busy", {63'd0, TxBusy}, 64'd0);
        check_eq("arst_ready", {63'd0, Ready}, 64'd1);
        check_eq("arst_strobe", {63'd0, BitStrobe}, 64'd0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        clear_stats();
        cycle(1'b1, 32'h0000_0001, 6'd1, 1'b0, 16'd0, 1'b0);
        idle_cycles(6);
        check_eq("one_bits", rec[0], 64'd1);
        check_eq("one_busy", n_busy, 1);
        check_eq("one_done", n_done, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom(), 6'($urandom_range(0, 40)),
                  1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)),
                  $urandom_range(0, 79) == 0);
        end
        idle_cycles(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_tx_buffered.md
Name: serial_tx_buffered

Overview:
Parametrised, double-buffered serial transmitter. Serialises a programmable-length word onto Dout at a programmable bit rate, derived from a clock divider. All logic runs in the single Clk domain; there is no separate transmit clock. A holding register accepts the next word while the current one shifts, so frames can be sent back-to-back with no gap. Per-frame options are bit order, frame length and bit period, plus abort and done/busy status.

Parameters:
WIDTH, 32, maximum data word width in bits (>= 2)
DIV_W, 16, width of the bit-period divider value
LEN_W, $clog2(WIDTH+1), width of the Len port (localparam, derived)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-high reset
DataIn  in  WIDTH  word to transmit; frame uses bits [Len_eff-1:0]
Load  in  1  write DataIn/Len/LsbFirst/BitDiv into holding register; accepted only when Ready=1
Len  in  LEN_W  frame length in bits; 0 or >WIDTH means WIDTH
LsbFirst  in  1  1 = bit 0 first; 0 = bit Len_eff-1 first
BitDiv  in  DIV_W  clocks per bit minus 1 (bit period = BitDiv+1 cycles)
Abort  in  1  synchronous abort of current frame and pending word
Ready  out  1  holding register empty
TxBusy  out  1  frame in progress
TxDone  out  1  one-cycle pulse on normal frame completion
BitStrobe  out  1  one-cycle pulse in the first cycle each new bit appears on Dout
Dout  out  1  serial data; 0 when idle

Behaviour:
- Reset (async, any time including mid-frame): Dout=0, TxBusy=0, TxDone=0, BitStrobe=0, Ready=1. Holding register, shifter and all counters clear. The first edge after deassertion behaves as IDLE.
- Holding register:
  - Load && Ready at edge k captures DataIn, Len_eff, LsbFirst and BitDiv; hold_valid=1, Ready=0 after edge k.
  - Load with Ready=0 is ignored; no overwrite.
- States: IDLE, SHIFT. TxBusy = (state==SHIFT).
- IDLE with hold_valid at edge k+1 (transfer):
  - shifter <= held word; per-frame config latched from holding register; hold_valid<=0 (Ready=1 after k+1).
  - Dout <= first bit; BitStrobe=1; div_cnt<=BitDiv; bit_cnt<=Len_eff-1; state<=SHIFT.
  - Latency is Load-edge to first Dout bit = 1 cycle.
- SHIFT:
  - div_cnt != 0: decrement, Dout holds.
  - div_cnt==0 and bit_cnt!=0: present next bit (LSB-first: next higher index; MSB-first: next lower), BitStrobe=1, bit_cnt-1, div_cnt<=latched BitDiv.
  - div_cnt==0 and bit_cnt==0: frame end, TxDone=1 for that cycle.
    - If hold_valid: perform transfer in the same edge (back-to-back, zero idle cycles, BitStrobe=1, stays SHIFT).
    - Else: Dout<=0, state<=IDLE.
- Frame duration is exactly Len_eff*(BitDiv+1) cycles of Dout activity.
- Changes to Len/LsbFirst/BitDiv/DataIn after Load have no effect on the queued or current frame.
- Abort (any state):
  - Next edge: state<=IDLE, Dout<=0, hold_valid<=0 (Ready=1), counters cleared, TxDone stays 0, BitStrobe 0.
  - Abort has priority over Load and over a coinciding frame end. If Abort and frame end coincide, TxDone is not pulsed.
- Load in the same cycle as a transfer cannot collide: transfer requires hold_valid=1, hence Ready=0.
- BitDiv=0: one bit per cycle, BitStrobe high every cycle of the frame.
- Len_eff=1: single-bit frame, TxDone at the end of that bit period.
- Outputs TxDone, BitStrobe, Dout, TxBusy are registered; Ready is registered (= !hold_valid).

Test Plan:
- Reset then Load DataIn=32'hA5000000, Len=8 (Len_eff=8), LsbFirst=0, BitDiv=0 -> Dout sequence is bits [7:0] of the word, MSB first: 0,0,0,0,0,0,0,0. Also Load DataIn=32'h000000A5 -> Dout 1,0,1,0,0,1,0,1 on 8 consecutive cycles; BitStrobe high each cycle; TxDone pulse in the 8th bit cycle; Dout=0 and TxBusy=0 afterwards.
- DataIn=32'h000000A5, Len=8, LsbFirst=1, BitDiv=3 -> Dout 1,0,1,0,0,1,0,1, each bit held 4 cycles; BitStrobe every 4th cycle; frame exactly 32 cycles.
- Load word A (Len=4, 4'hC, MSB-first, BitDiv=1), then Load word B (Len=4, 4'h3) as soon as Ready=1 -> Dout 1,1,0,0,0,0,1,1 (2 cycles each) with no idle gap; TxBusy stays 1 throughout; two TxDone pulses 8 cycles apart; Ready low while B is pending.
- Len=0, DataIn=32'h80000001, MSB-first, BitDiv=0 -> 32-bit frame: Dout=1 first, 30 zeros, Dout=1 last; TxDone at cycle 32. Len=40 behaves identically.
- Abort asserted mid-frame at bit 3 with a second word pending -> next edge Dout=0, TxBusy=0, Ready=1, no TxDone, pending word discarded, no further Dout activity.
- Async Reset pulse mid-frame (between clock edges) -> outputs go to reset values immediately. A subsequent Load of 32'h1, Len=1, BitDiv=0 sends a single 1 followed by a TxDone pulse.
